// File: rtl/chop_seq_ctrl_if.sv
// Control/config bus between the register front-end and the chopper run controller,
// plus the enable/count lines the controller drives toward the chopper generator.
interface chop_seq_ctrl_if;
  logic        start;
  logic        stop;
  logic        chop_default;
  logic        cfg_wr;
  logic [31:0] cfg_change_count;
  logic [31:0] cfg_max_count;
  logic [15:0] cfg_num_periods;
  logic        chop_i;
  logic        chop_en_o;
  logic [31:0] change_count_o;
  logic [31:0] max_count_o;
  logic        busy_o;
  logic        done_o;
  logic        cfg_err_o;
  logic        cfg_pending_o;
  logic        wdog_err_o;
  logic [15:0] period_cnt_o;

  modport master (
    output start, stop, chop_default, cfg_wr, cfg_change_count, cfg_max_count,
           cfg_num_periods, chop_i,
    input  chop_en_o, change_count_o, max_count_o, busy_o, done_o, cfg_err_o,
           cfg_pending_o, wdog_err_o, period_cnt_o
  );

  modport slave (
    input  start, stop, chop_default, cfg_wr, cfg_change_count, cfg_max_count,
           cfg_num_periods, chop_i,
    output chop_en_o, change_count_o, max_count_o, busy_o, done_o, cfg_err_o,
           cfg_pending_o, wdog_err_o, period_cnt_o
  );
endinterface

// File: rtl/chop_seq_ctrl.sv
// Run controller for the chopper generator: arm/run/stop/burst sequencing, boundary-aligned
// config updates and a watchdog on the returned chop signal.
module chop_seq_ctrl #(
  parameter int unsigned ARM_CYCLES  = 4,
  parameter int unsigned WDOG_MARGIN = 16
) (
  input  logic           clk,
  input  logic           reset_n,
  chop_seq_ctrl_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_RUN,
    S_STOPPING,
    S_ERR
  } state_t;

  state_t      state_q, state_d;
  logic        chop_q;
  logic [31:0] act_chg_q, act_chg_d, act_max_q, act_max_d;
  logic [31:0] sh_chg_q, sh_chg_d, sh_max_q, sh_max_d;
  logic        pend_q, pend_d;
  logic        cfg_err_q, cfg_err_d;
  logic        done_q, done_d;
  logic [15:0] num_q, num_d;
  logic [15:0] period_q, period_d;
  logic [32:0] wd_q, wd_d;
  logic [31:0] arm_q, arm_d;

  logic        bnd;
  logic        cfg_valid;
  logic [32:0] wd_limit;
  logic [15:0] period_inc;
  logic        final_bnd;

  assign bnd        = (chop_q == ~bus.chop_default) && (bus.chop_i == bus.chop_default);
  assign cfg_valid  = (bus.cfg_max_count >= 32'd2) && (bus.cfg_change_count >= 32'd1) &&
                      (bus.cfg_change_count < bus.cfg_max_count);
  assign wd_limit   = {1'b0, act_max_q} + 33'(WDOG_MARGIN);
  assign period_inc = (period_q == '1) ? period_q : period_q + 16'd1;
  assign final_bnd  = bnd && (num_q != '0) && (period_inc == num_q);

  always_comb begin
    state_d   = state_q;
    act_chg_d = act_chg_q;
    act_max_d = act_max_q;
    sh_chg_d  = sh_chg_q;
    sh_max_d  = sh_max_q;
    pend_d    = pend_q;
    cfg_err_d = cfg_err_q;
    done_d    = 1'b0;
    num_d     = num_q;
    period_d  = period_q;
    wd_d      = wd_q;
    arm_d     = arm_q;

    if (bus.cfg_wr) cfg_err_d = !cfg_valid;

    unique case (state_q)
      S_IDLE: begin
        if (pend_q) begin
          act_chg_d = sh_chg_q;
          act_max_d = sh_max_q;
          pend_d    = 1'b0;
        end
        if (bus.cfg_wr && cfg_valid) begin
          act_chg_d = bus.cfg_change_count;
          act_max_d = bus.cfg_max_count;
        end
        if (bus.start && !cfg_err_q) begin
          state_d  = S_ARM;
          arm_d    = '0;
          period_d = '0;
          wd_d     = '0;
          num_d    = bus.cfg_num_periods;
        end
      end
      S_ARM: begin
        if (bus.stop) begin
          state_d = S_IDLE;
        end else if (arm_q == 32'(ARM_CYCLES - 1)) begin
          state_d = S_RUN;
          wd_d    = '0;
        end else begin
          arm_d = arm_q + 32'd1;
        end
      end
      S_RUN, S_STOPPING: begin
        if (bnd) begin
          period_d = period_inc;
          wd_d     = '0;
          if (pend_q) begin
            act_chg_d = sh_chg_q;
            act_max_d = sh_max_q;
            pend_d    = 1'b0;
          end
          // Final burst boundary wins over a coincident stop so done pulses once.
          if (final_bnd || (state_q == S_STOPPING)) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else if (bus.stop) begin
            state_d = S_STOPPING;
          end
        end else if ((wd_q + 33'd1) >= wd_limit) begin
          state_d = S_ERR;
        end else begin
          wd_d = wd_q + 33'd1;
          if (bus.stop) state_d = S_STOPPING;
        end
      end
      S_ERR: begin
        if (bus.stop) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // A write landing on a boundary cycle is staged after that boundary's apply.
    if (bus.cfg_wr && cfg_valid && (state_q != S_IDLE)) begin
      sh_chg_d = bus.cfg_change_count;
      sh_max_d = bus.cfg_max_count;
      pend_d   = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      chop_q    <= 1'b0;
      act_chg_q <= 32'd1;
      act_max_q <= 32'd2;
      sh_chg_q  <= '0;
      sh_max_q  <= '0;
      pend_q    <= 1'b0;
      cfg_err_q <= 1'b0;
      done_q    <= 1'b0;
      num_q     <= '0;
      period_q  <= '0;
      wd_q      <= '0;
      arm_q     <= '0;
    end else begin
      state_q   <= state_d;
      chop_q    <= bus.chop_i;
      act_chg_q <= act_chg_d;
      act_max_q <= act_max_d;
      sh_chg_q  <= sh_chg_d;
      sh_max_q  <= sh_max_d;
      pend_q    <= pend_d;
      cfg_err_q <= cfg_err_d;
      done_q    <= done_d;
      num_q     <= num_d;
      period_q  <= period_d;
      wd_q      <= wd_d;
      arm_q     <= arm_d;
    end
  end

  assign bus.chop_en_o      = (state_q == S_RUN) || (state_q == S_STOPPING);
  assign bus.busy_o         = (state_q == S_ARM) || (state_q == S_RUN) || (state_q == S_STOPPING);
  assign bus.wdog_err_o     = (state_q == S_ERR);
  assign bus.change_count_o = act_chg_q;
  assign bus.max_count_o    = act_max_q;
  assign bus.done_o         = done_q;
  assign bus.cfg_err_o      = cfg_err_q;
  assign bus.cfg_pending_o  = pend_q;
  assign bus.period_cnt_o   = period_q;

endmodule

// File: tb/tb_chop_seq_ctrl.sv
// Directed bench for chop_seq_ctrl: cycle model of the run rules checked every cycle,
// plus literal expectations at key points of each scenario.
module tb_chop_seq_ctrl;
  localparam int unsigned ARM  = 4;
  localparam int unsigned WDOG = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   checks = 0;
  int   errors = 0;
  int   done_seen = 0;

  chop_seq_ctrl_if bus ();

  chop_seq_ctrl #(.ARM_CYCLES(ARM), .WDOG_MARGIN(WDOG)) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  // Behavioural model of the run rules
  int          m_arm_left = 0;
  bit          m_run = 0, m_stopping = 0, m_fault = 0, m_pend = 0, m_err = 0, m_done = 0;
  bit          m_prev_chop = 0;
  logic [31:0] m_chg = 1, m_max = 2, m_sh_chg = 0, m_sh_max = 0;
  int          m_periods = 0, m_burst = 0;
  longint      m_since = 0;

  always @(posedge clk or negedge reset_n) begin : model
    bit bnd, ok, was_idle, old_err;
    if (!reset_n) begin
      m_arm_left = 0; m_run = 0; m_stopping = 0; m_fault = 0;
      m_chg = 1; m_max = 2; m_sh_chg = 0; m_sh_max = 0; m_pend = 0;
      m_err = 0; m_done = 0; m_periods = 0; m_burst = 0; m_since = 0; m_prev_chop = 0;
    end else begin
      bnd = (m_prev_chop != bus.chop_default) && (bus.chop_i == bus.chop_default);
      m_prev_chop = bus.chop_i;
      ok = (bus.cfg_max_count >= 2) && (bus.cfg_change_count >= 1) &&
           (bus.cfg_change_count < bus.cfg_max_count);
      was_idle = (m_arm_left == 0) && !m_run && !m_stopping && !m_fault;
      old_err = m_err;
      if (bus.cfg_wr) m_err = !ok;
      m_done = 0;
      if (m_run || m_stopping) begin
        if (bnd) begin
          if (m_periods < 65535) m_periods++;
          m_since = 0;
          if (m_pend) begin m_chg = m_sh_chg; m_max = m_sh_max; m_pend = 0; end
          if (m_stopping || (m_burst != 0 && m_periods == m_burst)) begin
            m_run = 0; m_stopping = 0; m_done = 1;
          end else if (bus.stop) begin
            m_run = 0; m_stopping = 1;
          end
        end else begin
          m_since++;
          if (m_since >= longint'(m_max) + longint'(WDOG)) begin
            m_run = 0; m_stopping = 0; m_fault = 1;
          end else if (bus.stop && m_run) begin
            m_run = 0; m_stopping = 1;
          end
        end
      end else if (m_arm_left != 0) begin
        if (bus.stop) m_arm_left = 0;
        else begin
          m_arm_left--;
          if (m_arm_left == 0) begin m_run = 1; m_since = 0; end
        end
      end else if (m_fault) begin
        if (bus.stop) m_fault = 0;
      end else begin
        if (m_pend) begin m_chg = m_sh_chg; m_max = m_sh_max; m_pend = 0; end
        if (bus.cfg_wr && ok) begin m_chg = bus.cfg_change_count; m_max = bus.cfg_max_count; end
        if (bus.start && !old_err) begin
          m_arm_left = ARM; m_periods = 0; m_burst = int'(bus.cfg_num_periods);
        end
      end
      if (bus.cfg_wr && ok && !was_idle) begin
        m_sh_chg = bus.cfg_change_count; m_sh_max = bus.cfg_max_count; m_pend = 1;
      end
    end
  end

  always @(negedge clk) begin
    chk("chop_en", bus.chop_en_o, m_run || m_stopping);
    chk("busy", bus.busy_o, (m_arm_left != 0) || m_run || m_stopping);
    chk("wdog_err", bus.wdog_err_o, m_fault);
    chk("done", bus.done_o, m_done);
    chk("cfg_err", bus.cfg_err_o, m_err);
    chk("cfg_pending", bus.cfg_pending_o, m_pend);
    chk("change_count", bus.change_count_o, m_chg);
    chk("max_count", bus.max_count_o, m_max);
    chk("period_cnt", bus.period_cnt_o, m_periods);
    if (bus.done_o) done_seen++;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  task automatic cfg(input logic [31:0] c, input logic [31:0] m, input logic [15:0] np);
    bus.cfg_change_count = c; bus.cfg_max_count = m; bus.cfg_num_periods = np;
    bus.cfg_wr = 1'b1; tick(); bus.cfg_wr = 1'b0;
  endtask

  task automatic pulse_start(); bus.start = 1'b1; tick(); bus.start = 1'b0; endtask
  task automatic pulse_stop();  bus.stop  = 1'b1; tick(); bus.stop  = 1'b0; endtask

  task automatic wait_en();
    int n = 0;
    while (!bus.chop_en_o && n < 30) begin tick(); n++; end
    chk("wait_en_bound", bus.chop_en_o, 1);
  endtask

  task automatic chop_period(input int hi, input int lo);
    bus.chop_i = ~bus.chop_default; tick(hi);
    bus.chop_i = bus.chop_default;  tick(lo);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int n, d0;
    bus.start = 0; bus.stop = 0; bus.chop_default = 0; bus.cfg_wr = 0;
    bus.cfg_change_count = 0; bus.cfg_max_count = 0; bus.cfg_num_periods = 0; bus.chop_i = 0;
    tick(3);
    chk("rst_chop_en", bus.chop_en_o, 0);
    chk("rst_change", bus.change_count_o, 1);
    chk("rst_max", bus.max_count_o, 2);
    chk("rst_period", bus.period_cnt_o, 0);
    reset_n = 1'b1;
    tick(2);

    // Burst of 3 at 5/10
    cfg(5, 10, 3);
    chk("idle_load_change", bus.change_count_o, 5);
    chk("idle_load_pending", bus.cfg_pending_o, 0);
    d0 = done_seen;
    pulse_start();
    n = 1;
    while (!bus.chop_en_o && n < 20) begin tick(); n++; end
    chk("arm_latency", n, 5);
    for (int p = 1; p <= 3; p++) begin
      chop_period(5, 5);
      chk("burst_period_cnt", bus.period_cnt_o, p);
    end
    chk("burst_done_count", done_seen - d0, 1);
    chk("burst_en_low", bus.chop_en_o, 0);

    // Config validation
    cfg(10, 10, 0);
    chk("invalid_err", bus.cfg_err_o, 1);
    chk("invalid_keeps_max", bus.max_count_o, 10);
    pulse_start();
    chk("start_ignored_cfg_err", bus.busy_o, 0);
    cfg(3, 8, 0);
    chk("valid_clears_err", bus.cfg_err_o, 0);
    chk("valid_loads_max", bus.max_count_o, 8);

    // Continuous run with boundary-aligned updates
    cfg(5, 10, 0);
    pulse_start(); wait_en();
    chop_period(5, 5);
    bus.chop_i = 1; tick(2);
    cfg(2, 6, 0);
    chk("pending_set", bus.cfg_pending_o, 1);
    chk("pending_holds_change", bus.change_count_o, 5);
    tick(2);
    bus.chop_i = 0; tick();
    chk("applied_change", bus.change_count_o, 2);
    chk("applied_max", bus.max_count_o, 6);
    tick(3);
    bus.chop_i = 1; tick();
    cfg(1, 5, 0); tick(2);
    bus.chop_i = 0;
    cfg(3, 7, 0);
    chk("coincident_change", bus.change_count_o, 1);
    chk("coincident_pending", bus.cfg_pending_o, 1);
    tick(3);
    chop_period(3, 3);
    chk("coincident_next_max", bus.max_count_o, 7);

    // Graceful stop mid-period
    bus.chop_i = 1; tick(2);
    d0 = done_seen;
    pulse_stop(); tick(2);
    chk("stopping_en_held", bus.chop_en_o, 1);
    bus.chop_i = 0; tick();
    chk("stop_done_count", done_seen - d0, 1);
    chk("stop_en_low", bus.chop_en_o, 0);

    // Stop during ARM
    d0 = done_seen;
    pulse_start(); tick();
    pulse_stop();
    chk("arm_stop_idle", bus.busy_o, 0);
    tick(2);
    chk("arm_stop_no_done", done_seen - d0, 0);

    // Watchdog with chop stuck away from default
    cfg(5, 10, 0);
    bus.chop_i = 1;
    pulse_start(); wait_en();
    n = 0;
    while (!bus.wdog_err_o && n < 100) begin tick(); n++; end
    chk("wdog_latency", n, 26);
    pulse_start();
    chk("err_start_ignored", bus.wdog_err_o, 1);
    pulse_stop();
    chk("err_stop_clears", bus.wdog_err_o, 0);
    bus.chop_i = 0; tick(2);

    // Burst with chop idle level high
    bus.chop_default = 1; bus.chop_i = 1; tick();
    bus.cfg_num_periods = 2;
    pulse_start(); wait_en();
    chop_period(4, 4);
    chop_period(4, 4);
    chk("def1_period_cnt", bus.period_cnt_o, 2);
    chk("def1_idle", bus.busy_o, 0);
    bus.chop_default = 0; bus.chop_i = 0; tick(2);

    // Reset mid-run
    bus.cfg_num_periods = 0;
    pulse_start(); wait_en();
    chop_period(3, 3);
    @(posedge clk); #2;
    reset_n = 1'b0; #1;
    chk("async_rst_en", bus.chop_en_o, 0);
    chk("async_rst_busy", bus.busy_o, 0);
    chk("async_rst_period", bus.period_cnt_o, 0);
    chk("async_rst_max", bus.max_count_o, 2);
    tick(2);
    reset_n = 1'b1; tick();
    bus.cfg_num_periods = 1;
    pulse_start(); wait_en();
    chk("post_rst_change", bus.change_count_o, 1);
    chk("post_rst_max", bus.max_count_o, 2);
    d0 = done_seen;
    chop_period(2, 2);
    chk("post_rst_done", done_seen - d0, 1);
    chk("post_rst_period", bus.period_cnt_o, 1);
    tick(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
